// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
// The datapath supplies the instruction register and flags; the controller returns every strobe.
interface multicycle_controller_if #(
  parameter int STATE_W = 4
);
  logic [31:0]        INSTRUCTION;
  logic [3:0]         FLAGS;
  logic               A3Src;
  logic               WD3Src;
  logic               AdrSrc;
  logic               IRWrite;
  logic               PCWrite;
  logic               MemWrite;
  logic               RegWrite;
  logic               FlagUpdate;
  logic [1:0]         ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic [1:0]         ResultSrc;
  logic [1:0]         RegSrc;
  logic [2:0]         ALUop;
  logic [2:0]         ShiftType;
  logic [STATE_W-1:0] STATE_OUT;

  modport master (
    input  INSTRUCTION, FLAGS,
    output A3Src, WD3Src, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, FlagUpdate,
    output ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ALUop, ShiftType, STATE_OUT
  );

  modport slave (
    output INSTRUCTION, FLAGS,
    input  A3Src, WD3Src, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, FlagUpdate,
    input  ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ALUop, ShiftType, STATE_OUT
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle datapath: sequences fetch, decode and
// LDR/STR/data-processing/branch execution, with ARM condition evaluation in DECODE.
module multicycle_controller #(
  parameter int STATE_W = 4
) (
  input logic                    clock,
  input logic                    reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMREAD = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECR   = 4'd6,
    EXECI   = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9
  } state_t;

  state_t state_q, state_d;
  logic   condEx_q, condEx_d;

  logic [1:0] op;
  logic       iBit, sBit, linkBit, condPass, cmdKnown;
  logic [3:0] cmd, cond;
  logic [2:0] aluCmd;
  logic       nF, zF, cF, vF;
  logic       unusedInstrBits;

  assign op      = bus.INSTRUCTION[27:26];
  assign iBit    = bus.INSTRUCTION[25];
  assign cmd     = bus.INSTRUCTION[24:21];
  assign sBit    = bus.INSTRUCTION[20];
  assign linkBit = bus.INSTRUCTION[24];
  assign cond    = bus.INSTRUCTION[31:28];
  assign {nF, zF, cF, vF} = bus.FLAGS;
  assign unusedInstrBits  = ^{bus.INSTRUCTION[19:7], bus.INSTRUCTION[4:0]};

  always_comb begin
    unique case (cond)
      4'b0000: condPass = zF;
      4'b0001: condPass = ~zF;
      4'b0010: condPass = cF;
      4'b0011: condPass = ~cF;
      4'b0100: condPass = nF;
      4'b0101: condPass = ~nF;
      4'b0110: condPass = vF;
      4'b0111: condPass = ~vF;
      4'b1000: condPass = cF & ~zF;
      4'b1001: condPass = ~cF | zF;
      4'b1010: condPass = (nF == vF);
      4'b1011: condPass = (nF != vF);
      4'b1100: condPass = ~zF & (nF == vF);
      4'b1101: condPass = zF | (nF != vF);
      4'b1110: condPass = 1'b1;
      default: condPass = 1'b0;
    endcase
  end

  // Unmapped commands still run through the ALU as ADD but must never write back.
  always_comb begin
    cmdKnown = 1'b1;
    unique case (cmd)
      4'b0100:          aluCmd = 3'b000;
      4'b0010, 4'b1010: aluCmd = 3'b001;
      4'b0000:          aluCmd = 3'b010;
      4'b1100:          aluCmd = 3'b011;
      4'b1101:          aluCmd = 3'b100;
      default: begin
        aluCmd   = 3'b000;
        cmdKnown = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d  = FETCH;
    condEx_d = condEx_q;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        condEx_d = condPass;
        if (condPass) begin
          case (op)
            2'b00:   state_d = iBit ? EXECI : EXECR;
            2'b01:   state_d = MEMADR;
            2'b10:   state_d = BRANCH;
            default: state_d = FETCH;
          endcase
        end
      end
      MEMADR:  state_d = sBit ? MEMREAD : MEMWR;
      MEMREAD: state_d = MEMWB;
      EXECR, EXECI: state_d = (cmd == 4'b1010) ? FETCH : ALUWB;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= FETCH;
      condEx_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      condEx_q <= condEx_d;
    end
  end

  logic irWr, pcWr, memWr, regWr, flagUpd;

  // Post-decode writes are additionally qualified by the latched condition result.
  always_comb begin
    bus.A3Src     = 1'b0;
    bus.WD3Src    = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.ResultSrc = 2'b00;
    bus.ALUop     = 3'b000;
    bus.RegSrc    = {op == 2'b01, op == 2'b10};
    bus.ShiftType = 3'b111;
    irWr    = 1'b0;
    pcWr    = 1'b0;
    memWr   = 1'b0;
    regWr   = 1'b0;
    flagUpd = 1'b0;
    case (state_q)
      FETCH: begin
        irWr          = 1'b1;
        pcWr          = 1'b1;
        bus.ALUSrcB   = 2'b11;
        bus.ResultSrc = 2'b10;
      end
      DECODE: begin
        bus.ALUSrcB   = 2'b11;
        bus.ResultSrc = 2'b10;
      end
      MEMADR: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
      end
      MEMREAD: bus.AdrSrc = 1'b1;
      MEMWB: begin
        bus.AdrSrc    = 1'b1;
        bus.ResultSrc = 2'b01;
        regWr         = condEx_q;
      end
      MEMWR: begin
        bus.AdrSrc = 1'b1;
        memWr      = condEx_q;
      end
      EXECR, EXECI: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = (state_q == EXECI) ? 2'b01 : 2'b00;
        bus.ALUop   = aluCmd;
        flagUpd     = sBit & condEx_q;
        if (state_q == EXECR) bus.ShiftType = {1'b0, bus.INSTRUCTION[6:5]};
      end
      ALUWB: regWr = cmdKnown & condEx_q;
      BRANCH: begin
        bus.ALUSrcA   = 2'b01;
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        pcWr          = condEx_q;
        regWr         = linkBit & condEx_q;
        bus.A3Src     = linkBit;
        bus.WD3Src    = linkBit;
      end
      default: ;
    endcase
  end

  assign bus.IRWrite    = irWr & reset;
  assign bus.PCWrite    = pcWr & reset;
  assign bus.MemWrite   = memWr & reset;
  assign bus.RegWrite   = regWr & reset;
  assign bus.FlagUpdate = flagUpd & reset;
  assign bus.STATE_OUT  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks LDR, DP, CMP, STR, branch and reset-abort sequences.
module tb_multicycle_controller;

  logic clock;
  logic reset;
  int   testCount;
  int   failCount;

  multicycle_controller_if #(.STATE_W(4)) bus ();

  multicycle_controller #(.STATE_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [3:0] flags);
    bus.INSTRUCTION = instr;
    bus.FLAGS       = flags;
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [4:0] enables();
    return {bus.IRWrite, bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.FlagUpdate};
  endfunction

  initial begin
    testCount = 0;
    failCount = 0;
    reset = 1'b0;
    applyStimulus(32'h0, 4'h0);

    #12;
    checkOutput("rst_state", bus.STATE_OUT, 0);
    checkOutput("rst_enables", enables(), 5'b00000);
    checkOutput("rst_srcb", bus.ALUSrcB, 2'b11);
    #5 reset = 1'b1;
    #1;
    checkOutput("fetch_en", enables(), 5'b11000);
    checkOutput("fetch_srcb", bus.ALUSrcB, 2'b11);

    // LDR R1,[R1,#64]
    applyStimulus(32'hE5911040, 4'h0);
    stepCycle(); checkOutput("ldr_dec", bus.STATE_OUT, 1);
    checkOutput("ldr_dec_en", enables(), 5'b00000);
    stepCycle(); checkOutput("ldr_adr", bus.STATE_OUT, 2);
    checkOutput("ldr_adr_src", {bus.ALUSrcA, bus.ALUSrcB}, 4'b0101);
    stepCycle(); checkOutput("ldr_rd", bus.STATE_OUT, 3);
    checkOutput("ldr_rd_en", {bus.AdrSrc, enables()}, 6'b100000);
    stepCycle(); checkOutput("ldr_wb", bus.STATE_OUT, 4);
    checkOutput("ldr_wb_out", {bus.AdrSrc, bus.ResultSrc, enables()}, {1'b1, 2'b01, 5'b00010});
    stepCycle(); checkOutput("ldr_end", bus.STATE_OUT, 0);

    // ADD R0,R1,R2
    applyStimulus(32'hE0810002, 4'h0);
    stepCycle(); checkOutput("add_dec", bus.STATE_OUT, 1);
    stepCycle(); checkOutput("add_exe", bus.STATE_OUT, 6);
    checkOutput("add_exe_out", {bus.ALUop, bus.ShiftType, bus.ALUSrcB, bus.FlagUpdate}, {3'b000, 3'b000, 2'b00, 1'b0});
    stepCycle(); checkOutput("add_wb", bus.STATE_OUT, 8);
    checkOutput("add_wb_out", {bus.ResultSrc, enables()}, {2'b00, 5'b00010});
    stepCycle(); checkOutput("add_end", bus.STATE_OUT, 0);

    // SUBS R0,R1,R2
    applyStimulus(32'hE0510002, 4'h0);
    stepCycle();
    stepCycle(); checkOutput("subs_exe", bus.STATE_OUT, 6);
    checkOutput("subs_exe_out", {bus.ALUop, bus.FlagUpdate}, {3'b001, 1'b1});
    stepCycle(); checkOutput("subs_wb", bus.STATE_OUT, 8);
    stepCycle(); checkOutput("subs_end", bus.STATE_OUT, 0);

    // CMP R1,R2 skips writeback
    applyStimulus(32'hE1510002, 4'h0);
    stepCycle();
    stepCycle(); checkOutput("cmp_exe", {bus.STATE_OUT, bus.ALUop, bus.FlagUpdate}, {4'd6, 3'b001, 1'b1});
    stepCycle(); checkOutput("cmp_end", bus.STATE_OUT, 0);

    // STR R3,[R0,#4]
    applyStimulus(32'hE5803004, 4'h0);
    stepCycle(); checkOutput("str_dec", {bus.STATE_OUT, bus.RegSrc}, {4'd1, 2'b10});
    stepCycle(); checkOutput("str_adr", bus.STATE_OUT, 2);
    stepCycle(); checkOutput("str_wr", {bus.STATE_OUT, bus.AdrSrc}, {4'd5, 1'b1});
    checkOutput("str_wr_en", enables(), 5'b00100);
    stepCycle(); checkOutput("str_end", {bus.STATE_OUT, bus.MemWrite, bus.RegWrite}, {4'd0, 2'b00});

    // BEQ taken
    applyStimulus(32'h0A000002, 4'b0100);
    stepCycle(); checkOutput("beq_dec", bus.STATE_OUT, 1);
    stepCycle(); checkOutput("beq_br", bus.STATE_OUT, 9);
    checkOutput("beq_br_out", {bus.ALUSrcA, bus.ALUSrcB, bus.RegSrc, enables(), bus.A3Src}, {2'b01, 2'b01, 2'b01, 5'b01000, 1'b0});
    stepCycle(); checkOutput("beq_end", bus.STATE_OUT, 0);

    // BEQ not taken
    applyStimulus(32'h0A000002, 4'b0000);
    stepCycle(); checkOutput("beqn_dec_en", enables(), 5'b00000);
    stepCycle(); checkOutput("beqn_end", bus.STATE_OUT, 0);

    // BL
    applyStimulus(32'hEB000002, 4'h0);
    stepCycle();
    stepCycle(); checkOutput("bl_br", bus.STATE_OUT, 9);
    checkOutput("bl_br_out", {bus.A3Src, bus.WD3Src, enables()}, {2'b11, 5'b01010});
    stepCycle(); checkOutput("bl_end", bus.STATE_OUT, 0);

    // Undefined op class returns to fetch
    applyStimulus(32'hEC000000, 4'h0);
    stepCycle();
    stepCycle(); checkOutput("undef_end", bus.STATE_OUT, 0);

    // Reset during MEMWR aborts the store
    applyStimulus(32'hE5803004, 4'h0);
    stepCycle();
    stepCycle();
    stepCycle(); checkOutput("abort_pre", {bus.STATE_OUT, bus.MemWrite}, {4'd5, 1'b1});
    #1 reset = 1'b0;
    #1; checkOutput("abort_now", {bus.STATE_OUT, enables()}, {4'd0, 5'b00000});
    stepCycle(); checkOutput("abort_hold", {bus.STATE_OUT, enables()}, {4'd0, 5'b00000});
    reset = 1'b1;
    #1; checkOutput("abort_rel", {bus.STATE_OUT, bus.MemWrite}, {4'd0, 1'b0});
    stepCycle(); checkOutput("abort_dec", {bus.STATE_OUT, bus.MemWrite}, {4'd1, 1'b0});

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
